mem_lsu: RTL
============

# mem_lsu

Memory-stage load/store unit of the sMIPS pipeline. It takes one memory operation from EX/MEM and checks alignment. It runs a single req/ack transaction on the data bus, with byte enables and replicated store lanes. For loads, it extracts the addressed byte/halfword and sign- or zero-extends it to 32 bits for write-back. It is the data-path counterpart of the ID-stage immediate extender: that block widens instruction fields on the way in, and this one widens memory data on the way back.

## Interface
- `MEM_OP_LENGTH`, default 4: width of `mem_op_i`; encodings come from `consts.vh`.
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: synchronous, active-low reset.
- `req_valid_i` in 1: EX/MEM holds a memory op.
- `req_ready_o` out 1: unit idle, can accept.
- `mem_op_i` in 4: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data, right-justified.
- `rd_i` in 5: load destination register.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: write.
- `bus_be_o` out 4: byte enables, bit n = byte lane n.
- `bus_addr_o` out 32: word address; bits [1:0] are forced to 0.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_ack_i` in 1: transaction complete; `bus_rdata_i` is valid in the same cycle.
- `bus_rdata_i` in 32: read word.
- `wb_valid_o` out 1: one-cycle completion pulse, for loads and stores.
- `wb_we_o` out 1: the completion writes `wb_rd_o`, i.e. it was a load with no exception.
- `wb_rd_o` out 5, `wb_data_o` out 32: write-back target and extended load data.
- `exc_adel_o`, `exc_ades_o` out 1: misaligned load/store, asserted with `wb_valid_o`.
- `exc_badvaddr_o` out 32: faulting byte address.
- `stall_o` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, BUS, DONE.
- **IDLE**
  - `req_ready_o`=1.
  - Accept happens when `req_valid_i` & op≠NONE. On accept, latch op, addr, wdata and rd.
  - Alignment rule: halfword ops need addr[0]=0; word ops need addr[1:0]=0.
  - Misaligned op: go to DONE with exception flags set. No bus transaction is issued.
  - Aligned op: go to BUS.
  - `req_valid_i` with op=NONE is ignored.
- **BUS**
  - `bus_req_o`=1. `bus_we_o`, `bus_be_o`, `bus_addr_o` and `bus_wdata_o` are registered and stay stable until ack.
  - On `bus_ack_i`: capture the extended load data and go to DONE.
- **DONE**
  - `wb_valid_o`=1 for exactly this cycle, then go to IDLE.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], data = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, data = {2{wdata[15:0]}}.
  - SW: be = 4'b1111, data = wdata.
- Load extraction is little-endian and reads are always be = 4'b1111.
  - LB/LBU: byte = rdata[8*addr[1:0]+:8], sign- or zero-extended.
  - LH/LHU: half = rdata[16*addr[1]+:16], sign- or zero-extended.
  - LW: the whole word.
- Stores complete with `wb_we_o`=0 and `wb_data_o`=0.
- Exceptions: `exc_badvaddr_o` = latched addr. `wb_we_o`=0. ADEL is set for load ops and ADES for store ops.
- `bus_ack_i` outside BUS is ignored.

## Timing
- Reset values (the cycle after an edge with `rst_n_i`=0): state IDLE, `req_ready_o`=1, and every other output 0.
- Aligned access accepted at cycle T:
  - `bus_req_o` is high from T+1 through the ack cycle A (A ≥ T+1; zero-wait ack gives A=T+1).
  - `wb_valid_o` is high at A+1.
  - The next accept is possible at A+2.
- Misaligned access accepted at T: `wb_valid_o` and the exception flag are high at T+1, and the bus stays untouched.
- `wb_*` and `exc_*` outputs hold their value only in DONE. They are 0 otherwise.
- Reset asserted mid-BUS: the next state is IDLE and `bus_req_o` drops. A late ack is ignored and no `wb_valid_o` is produced.
- Simultaneous `bus_ack_i` and reset: reset wins.

## Structure
- `consts.vh` gets `MEM_OP_LENGTH`, the `MEM_OP_*` encodings and the FSM state encodings, alongside the existing `EXT_OP_*` definitions.
- One combinational sub-module, `mem_load_ext`: inputs rdata, addr[1:0] and op; output the 32-bit extended value. The FSM, lane steering and registers live in `mem_lsu`.

## Test plan
- LB addr 0x1003, rdata 0x80FF_1234, ack after 0 waits:
  - `bus_req_o` is high for 1 cycle with be 4'b1111 and addr 0x1000.
  - The next cycle, `wb_data_o`=0xFFFF_FF80, `wb_we_o`=1 and rd is echoed.
- LHU addr 0x2002, rdata 0x8001_7FFF, 3 wait cycles:
  - `bus_req_o` is high for 4 cycles with stable outputs and `stall_o` high throughout.
  - `wb_data_o`=0x0000_8001.
- SB addr 0x3001, wdata 0x0000_00AB:
  - be 4'b0010, `bus_wdata_o`=0xABAB_ABAB, `bus_we_o`=1.
  - On completion `wb_valid_o`=1 and `wb_we_o`=0.
- LW at 0x4002 and SH at 0x4001:
  - No `bus_req_o`.
  - The next cycle has `exc_adel_o` (resp. `exc_ades_o`) = 1 and `exc_badvaddr_o`=0x4002 (resp. 0x4001).
- `rst_n_i`=0 during the second wait cycle of an LW, then an ack arrives after reset:
  - Outputs are 0 and the unit is IDLE.
  - No `wb_valid_o`, and `req_ready_o`=1.
- Back-to-back SW then LH with a zero-wait ack:
  - The second accept happens exactly 3 cycles after the first.
  - Spurious ack pulses while IDLE cause no effect.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: op encodings,
// FSM states and the store lane-steering helpers.
package mem_lsu_pkg;

  localparam int MEM_OP_WIDTH = 4;

  typedef logic [MEM_OP_WIDTH-1:0] mem_op_t;

  localparam mem_op_t MEM_OP_NONE = 4'd0;
  localparam mem_op_t MEM_OP_LB   = 4'd1;
  localparam mem_op_t MEM_OP_LBU  = 4'd2;
  localparam mem_op_t MEM_OP_LH   = 4'd3;
  localparam mem_op_t MEM_OP_LHU  = 4'd4;
  localparam mem_op_t MEM_OP_LW   = 4'd5;
  localparam mem_op_t MEM_OP_SB   = 4'd6;
  localparam mem_op_t MEM_OP_SH   = 4'd7;
  localparam mem_op_t MEM_OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input mem_op_t op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
    logic half_op;
    logic word_op;
    half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
    word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
    return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_be(input mem_op_t op, input logic [1:0] addr_lo);
    case (op)
      MEM_OP_SB: return 4'b0001 << addr_lo;
      MEM_OP_SH: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // Data is replicated across lanes so the slave just honours the byte enables.
  function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] wdata);
    case (op)
      MEM_OP_SB: return {4{wdata[7:0]}};
      MEM_OP_SH: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Picks the addressed byte/halfword out of a little-endian read word and
// widens it to 32 bits with sign or zero extension.
module mem_load_ext
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_op_t     op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = rdata[16*addr_lo[1] +: 16];
    case (op)
      MEM_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data = {24'd0, byte_sel};
      MEM_OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: data = {16'd0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: alignment check, one req/ack bus transaction,
// and a single-cycle write-back/exception pulse on completion.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int MEM_OP_LENGTH = MEM_OP_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [MEM_OP_LENGTH-1:0] mem_op_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  input  logic [4:0]               rd_i,
  output logic                     bus_req_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_be_o,
  output logic [31:0]              bus_addr_o,
  output logic [31:0]              bus_wdata_o,
  input  logic                     bus_ack_i,
  input  logic [31:0]              bus_rdata_i,
  output logic                     wb_valid_o,
  output logic                     wb_we_o,
  output logic [4:0]               wb_rd_o,
  output logic [31:0]              wb_data_o,
  output logic                     exc_adel_o,
  output logic                     exc_ades_o,
  output logic [31:0]              exc_badvaddr_o,
  output logic                     stall_o
);

  lsu_state_e  state_reg;
  mem_op_t     op_reg;
  logic [1:0]  addr_lo_reg;
  logic [4:0]  rd_reg;
  logic [31:0] load_data;

  mem_load_ext u_load_ext (
    .rdata   (bus_rdata_i),
    .addr_lo (addr_lo_reg),
    .op      (op_reg),
    .data    (load_data)
  );

  assign req_ready_o = (state_reg == ST_IDLE);
  assign stall_o     = (state_reg != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= ST_IDLE;
      op_reg         <= MEM_OP_NONE;
      addr_lo_reg    <= 2'b00;
      rd_reg         <= 5'd0;
      bus_req_o      <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_be_o       <= 4'd0;
      bus_addr_o     <= 32'd0;
      bus_wdata_o    <= 32'd0;
      wb_valid_o     <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_rd_o        <= 5'd0;
      wb_data_o      <= 32'd0;
      exc_adel_o     <= 1'b0;
      exc_ades_o     <= 1'b0;
      exc_badvaddr_o <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i && (mem_op_i != MEM_OP_NONE)) begin
            op_reg      <= mem_op_i;
            addr_lo_reg <= addr_i[1:0];
            rd_reg      <= rd_i;
            if (is_misaligned(mem_op_i, addr_i[1:0])) begin
              // Faulting accesses never reach the bus; report straight away.
              state_reg      <= ST_DONE;
              wb_valid_o     <= 1'b1;
              exc_adel_o     <= is_load(mem_op_i);
              exc_ades_o     <= is_store(mem_op_i);
              exc_badvaddr_o <= addr_i;
            end else begin
              state_reg   <= ST_BUS;
              bus_req_o   <= 1'b1;
              bus_we_o    <= is_store(mem_op_i);
              bus_be_o    <= is_store(mem_op_i) ? store_be(mem_op_i, addr_i[1:0]) : 4'b1111;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_wdata_o <= is_store(mem_op_i) ? store_data(mem_op_i, wdata_i) : 32'd0;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack_i) begin
            state_reg   <= ST_DONE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= 4'd0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            wb_valid_o  <= 1'b1;
            wb_we_o     <= is_load(op_reg);
            wb_rd_o     <= rd_reg;
            wb_data_o   <= is_load(op_reg) ? load_data : 32'd0;
          end
        end
        ST_DONE: begin
          state_reg      <= ST_IDLE;
          wb_valid_o     <= 1'b0;
          wb_we_o        <= 1'b0;
          wb_rd_o        <= 5'd0;
          wb_data_o      <= 32'd0;
          exc_adel_o     <= 1'b0;
          exc_ades_o     <= 1'b0;
          exc_badvaddr_o <= 32'd0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
